usb_crc_checker: RTL and testbench

Parametrised bit-serial CRC checker for the receive path of the Serial Interface Engine. It takes the de-stuffed, NRZI-decoded bit stream, frames packets with start/end strobes and updates the CRC on every accepted bit, with no buffering of the whole field. At end-of-packet it reports pass/fail against the USB residual. One instance with default parameters checks DATA-packet CRC16; a second instance with CRC5 parameters checks token CRC5. Received bits are forwarded downstream with one cycle of latency.

---
 rtl/usb_crc_checker.sv | 131 +++++++++++++
 tb/tb_usb_crc_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_checker.sv
// Bit-serial CRC checker for the SIE receive path.
// Frames packets with sop/eop, updates the CRC on every accepted bit and
// pulses crc_ok/crc_err one cycle after the eop bit. The input stream is
// forwarded downstream with one cycle of latency.
module usb_crc_checker #(
  parameter int unsigned          WIDTH    = 16,
  parameter logic [WIDTH-1:0]     POLY     = 16'h8005,
  parameter logic [WIDTH-1:0]     RESIDUAL = 16'h800D,
  parameter int unsigned          MAX_BITS = 8200,
  localparam int unsigned         CW       = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          din_valid,
  input  logic          sop,
  input  logic          eop,
  output logic          stream_out,
  output logic          stream_valid,
  output logic          busy,
  output logic [CW-1:0] bit_count,
  output logic          crc_ok,
  output logic          crc_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);
  localparam logic [CW-1:0] CNT_MIN = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovl_q, ovl_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             so_q, sv_q;
  logic             start_c;
  logic             pass_c;

  // One LFSR step: feedback from the register MSB xor the incoming bit.
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                input logic             b);
    logic fb;
    fb = c[WIDTH-1] ^ b;
    return {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign start_c = din_valid & sop;

  // Next-state, CRC/counter update and result evaluation.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ovl_d   = ovl_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    pass_c  = 1'b0;

    if (start_c) begin
      // sop restarts from all ones in any state, aborting a packet in RUN.
      crc_d   = crc_step({WIDTH{1'b1}}, din);
      cnt_d   = CW'(1);
      ovl_d   = 1'b0;
      state_d = eop ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (din_valid) begin
            crc_d = crc_step(crc_q, din);
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            ovl_d = ovl_q | (cnt_q == CNT_MAX);
            if (eop) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Result is registered so it appears exactly while DONE is held.
    pass_c = (crc_d == RESIDUAL) && (cnt_d >= CNT_MIN) && !ovl_d;
    if (state_d == S_DONE) begin
      ok_d  = pass_c;
      err_d = !pass_c;
    end
    busy_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      crc_q   <= '1;
      cnt_q   <= '0;
      ovl_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      so_q    <= din;
      sv_q    <= din_valid;
    end
  end

  assign stream_out   = so_q;
  assign stream_valid = sv_q;
  assign busy         = busy_q;
  assign bit_count    = cnt_q;
  assign crc_ok       = ok_q;
  assign crc_err      = err_q;

endmodule

// File: tb/tb_usb_crc_checker.sv
// Scoreboard bench for usb_crc_checker: a CRC16 and a CRC5 instance share one
// input stream; a polynomial-division reference model predicts each result.
module tb_usb_crc_checker;

  localparam int unsigned MAX16 = 8200;
  localparam int unsigned MAX5  = 40;
  localparam int unsigned CW16  = $clog2(MAX16 + 1);
  localparam int unsigned CW5   = $clog2(MAX5 + 1);

  logic clk;
  logic rst;
  logic din, din_valid, sop, eop;
  logic so16, sv16, busy16, ok16, err16;
  logic so5, sv5, busy5, ok5, err5;
  logic [CW16-1:0] bc16;
  logic [CW5-1:0]  bc5;

  typedef struct {
    bit ok;
    int cnt;
  } exp_t;

  exp_t q16[$];
  exp_t q5[$];
  exp_t last16, last5;
  bit   pkt[$];
  int   tests = 0;
  int   fails = 0;
  logic e_so, e_sv;

  usb_crc_checker u_dut16 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sop(sop), .eop(eop),
    .stream_out(so16), .stream_valid(sv16), .busy(busy16), .bit_count(bc16),
    .crc_ok(ok16), .crc_err(err16)
  );

  usb_crc_checker #(
    .WIDTH(5), .POLY(5'h05), .RESIDUAL(5'h0C), .MAX_BITS(MAX5)
  ) u_dut5 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sop(sop), .eop(eop),
    .stream_out(so5), .stream_valid(sv5), .busy(busy5), .bit_count(bc5),
    .crc_ok(ok5), .crc_err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register after a packet = (preset * x^n + M(x) * x^w) mod G, by long division.
  function automatic logic [15:0] ref_rem(input int w, input logic [15:0] poly, input bit bits[$]);
    bit a[$];
    int n;
    logic [15:0] r;
    n = bits.size();
    a = bits;
    repeat (w) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = ~a[i];
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = a[n+k];
    return r;
  endfunction

  function automatic exp_t ref_expect(input int w, input logic [15:0] poly, input logic [15:0] res,
                                      input int maxb, input bit bits[$]);
    exp_t e;
    int n;
    n = bits.size();
    e.ok  = (ref_rem(w, poly, bits) == res) && (n >= w) && (n <= maxb);
    e.cnt = (n > maxb) ? maxb : n;
    return e;
  endfunction

  // Random data followed by the complemented CRC, MSB first: a good packet.
  task automatic build_good(input int w, input logic [15:0] poly, input int nd);
    logic [15:0] r;
    pkt.delete();
    repeat (nd) pkt.push_back(bit'($urandom_range(0, 1)));
    r = ref_rem(w, poly, pkt);
    for (int k = 0; k < w; k++) pkt.push_back(~r[w-1-k]);
  endtask

  task automatic build_rand(input int n);
    pkt.delete();
    repeat (n) pkt.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic idle_bits(input int n);
    repeat (n) begin
      din = 1'($urandom); din_valid = 1'($urandom); sop = 1'b0; eop = 1'b0;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
  endtask

  // Drive pkt; gaps carry random sop/eop with din_valid low, which must be ignored.
  task automatic send_pkt(input bit with_eop, input int gap_pct);
    int n;
    n = pkt.size();
    if (with_eop) begin
      last16 = ref_expect(16, 16'h8005, 16'h800D, MAX16, pkt);
      last5  = ref_expect(5, 16'h0005, 16'h000C, MAX5, pkt);
      q16.push_back(last16);
      q5.push_back(last5);
    end
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        din = 1'($urandom); din_valid = 1'b0; sop = 1'($urandom); eop = 1'($urandom);
        @(posedge clk); #1;
      end
      din = pkt[i]; din_valid = 1'b1; sop = (i == 0); eop = with_eop && (i == n - 1);
      @(posedge clk); #1;
      if (i == 0 && !(with_eop && n == 1)) begin
        check("busy16_after_sop", 32'(busy16), 32'd1);
        check("busy5_after_sop", 32'(busy5), 32'd1);
      end
    end
    din_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    if (with_eop) begin
      check("busy16_after_eop", 32'(busy16), 32'd0);
      check("busy5_after_eop", 32'(busy5), 32'd0);
    end
  endtask

  // Expected forwarded stream: one-cycle delayed copy of the inputs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_so <= 1'b0;
      e_sv <= 1'b0;
    end else begin
      e_so <= din;
      e_sv <= din_valid;
    end
  end

  // Monitor: compare every result pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      check("stream16", 32'({so16, sv16}), 32'({e_so, e_sv}));
      check("stream5", 32'({so5, sv5}), 32'({e_so, e_sv}));
      if (ok16 && err16) check("both16", 32'({ok16, err16}), 32'd0);
      if (ok5 && err5) check("both5", 32'({ok5, err5}), 32'd0);
      if (ok16 || err16) begin
        if (q16.size() == 0) check("unexpected16", 32'({ok16, err16}), 32'd0);
        else begin
          e = q16.pop_front();
          check("ok16", 32'(ok16), 32'(e.ok));
          check("cnt16", 32'(bc16), 32'(e.cnt));
        end
      end
      if (ok5 || err5) begin
        if (q5.size() == 0) check("unexpected5", 32'({ok5, err5}), 32'd0);
        else begin
          e = q5.pop_front();
          check("ok5", 32'(ok5), 32'(e.ok));
          check("cnt5", 32'(bc5), 32'(e.cnt));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_so16"}, 32'({so16, sv16}), 32'd0);
    check({tag, "_so5"}, 32'({so5, sv5}), 32'd0);
    check({tag, "_busy"}, 32'({busy16, busy5}), 32'd0);
    check({tag, "_bc16"}, 32'(bc16), 32'd0);
    check({tag, "_bc5"}, 32'(bc5), 32'd0);
    check({tag, "_res"}, 32'({ok16, err16, ok5, err5}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; din = 1'b0; din_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    idle_bits(5);

    // Zero-length DATA packet, then the same with one bit corrupted.
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    send_pkt(1'b1, 0);
    pkt[7] = ~pkt[7];
    send_pkt(1'b1, 0);

    // CRC5 zero packet, 3-bit short packet, single-bit sop+eop packet.
    pkt.delete();
    repeat (5) pkt.push_back(1'b0);
    send_pkt(1'b1, 0);
    build_rand(3);
    send_pkt(1'b1, 0);
    build_rand(1);
    send_pkt(1'b1, 0);
    idle_bits(4);

    // Abort by sop in RUN, followed by a good packet.
    build_rand(10);
    send_pkt(1'b0, 0);
    pkt.delete();
    repeat (16) pkt.push_back(1'b0);
    send_pkt(1'b1, 0);

    // Randomized mix of good, corrupted and random packets, with gaps.
    for (int t = 0; t < 40; t++) begin
      case (t % 4)
        0: build_good(16, 16'h8005, int'($urandom_range(0, 48)));
        1: build_good(5, 16'h0005, int'($urandom_range(0, 30)));
        2: begin
          int p;
          build_good(16, 16'h8005, int'($urandom_range(0, 40)));
          p = int'($urandom_range(0, pkt.size() - 1));
          pkt[p] = ~pkt[p];
        end
        default: build_rand(int'($urandom_range(1, 40)));
      endcase
      send_pkt(1'b1, (t % 3 == 0) ? 0 : 30);
      if ($urandom_range(0, 1) == 1) idle_bits(int'($urandom_range(0, 3)));
    end

    // Back-to-back: eop in cycle N, sop in cycle N+1.
    build_good(16, 16'h8005, 8);
    send_pkt(1'b1, 0);
    build_good(5, 16'h0005, 6);
    send_pkt(1'b1, 0);
    idle_bits(3);

    // Length boundaries for both instances.
    build_good(5, 16'h0005, 36);
    send_pkt(1'b1, 0);
    build_good(5, 16'h0005, 35);
    send_pkt(1'b1, 10);
    build_good(16, 16'h8005, int'(MAX16) - 15);
    send_pkt(1'b1, 0);
    idle_bits(2);
    build_good(16, 16'h8005, int'(MAX16) - 16);
    send_pkt(1'b1, 0);
    idle_bits(3);

    // Asynchronous reset in the middle of a packet.
    build_rand(20);
    send_pkt(1'b0, 0);
    din_valid = 1'b1;
    #3 rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    din_valid = 1'b0;
    build_good(16, 16'h8005, 12);
    send_pkt(1'b1, 20);

    // bit_count holds through IDLE; every predicted result was seen.
    idle_bits(6);
    check("hold_bc16", 32'(bc16), 32'(last16.cnt));
    check("hold_bc5", 32'(bc5), 32'(last5.cnt));
    check("pending16", 32'(q16.size()), 32'd0);
    check("pending5", 32'(q5.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
